inst_mem_responder: RTL and testbench

Instruction-memory responder serving fetch requests from the instruction-fetch stage over a request/acknowledge handshake. It holds a word-addressed program store with a separate load (write) port, inserts a programmable number of wait states before each response, and flags out-of-range or misaligned fetches. It sits between the fetch stage and the program loader in the CPU top level.

---
 rtl/inst_mem_pkg.sv | 13 +
 rtl/inst_mem_array.sv | 37 +++
 rtl/inst_mem_responder.sv | 109 ++++++++++
 tb/tb_inst_mem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared types and constants for the instruction-memory responder
package inst_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam int          CNT_W = 4;

endpackage

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - word-addressed program store, one registered read port, one write port
module inst_mem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Same-edge read of a word being written sees the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - fetch responder with programmable wait states over a program store
// Range/alignment fault checking is compiled in when INST_MEM_ERR_EN is defined.
module inst_mem_responder
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [31:0]       addr_i,
  output logic              ack_o,
  output logic [31:0]       inst_o,
  output logic              err_o,
  output logic              busy_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              err_q;
  logic              capture;
  logic              rd_fire;
  logic              fault;
  logic [31:0]       rd_addr;
  logic [31:0]       rdata;
  logic              unused_addr_bits;

  assign capture = req_i && ((state_q == ST_IDLE) || (state_q == ST_RESP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (rd_fire) begin
        err_q <= fault;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (capture) begin
          addr_d  = addr_i;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A direct capture into RESP (no wait states) reads the live address.
  always_comb begin
    ack_o   = (state_q == ST_RESP);
    busy_o  = (state_q != ST_IDLE);
    rd_fire = (state_d == ST_RESP);
    rd_addr = capture ? addr_i : addr_q;
`ifdef INST_MEM_ERR_EN
    fault   = (rd_addr[1:0] != 2'b00) || (rd_addr[31:ADDR_W+2] != '0);
`else
    fault   = 1'b0;
`endif
  end

  assign unused_addr_bits = ^{rd_addr[31:ADDR_W+2], rd_addr[1:0]};

  inst_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst),
    .re_i    (rd_fire && !fault),
    .raddr_i (rd_addr[ADDR_W+1:2]),
    .rdata_o (rdata),
    .we_i    (we_i && rst),
    .waddr_i (waddr_i),
    .wdata_i (wdata_i)
  );

  assign inst_o = err_q ? NOP : rdata;
  assign err_o  = err_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - scoreboard bench for inst_mem_responder (WAIT_CYCLES=2 and 0)
module tb_inst_mem_responder;

  localparam int ADDR_W = 10;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          k;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              req2, ack2, err2, busy2, we2;
  logic [31:0]       addr2, inst2, wdata2;
  logic [ADDR_W-1:0] waddr2;
  logic              req0, ack0, err0, busy0, we0;
  logic [31:0]       addr0, inst0, wdata0;
  logic [ADDR_W-1:0] waddr0;

  int    checks = 0;
  int    errors = 0;
  resp_t exp_q[$];
  resp_t obs_q[$];
  logic  busy_k1, end_busy;

  inst_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req_i(req2), .addr_i(addr2), .ack_o(ack2), .inst_o(inst2),
    .err_o(err2), .busy_o(busy2), .we_i(we2), .waddr_i(waddr2), .wdata_i(wdata2)
  );

  inst_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .addr_i(addr0), .ack_o(ack0), .inst_o(inst0),
    .err_o(err0), .busy_o(busy0), .we_i(we0), .waddr_i(waddr0), .wdata_i(wdata0)
  );

  task automatic wr2(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    we2 = 1'b1; waddr2 = a; wdata2 = d;
    @(posedge clk); #1;
    we2 = 1'b0;
  endtask

  task automatic wr0(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    we0 = 1'b1; waddr0 = a; wdata0 = d;
    @(posedge clk); #1;
    we0 = 1'b0;
  endtask

  // mode 0: plain pulse; 1: re-request addr 8 during WAIT; 2: write word 5 on the RESP-entry edge
  task automatic run_fetch2(input logic [31:0] a, input int mode);
    resp_t r;
    @(posedge clk); #1;
    req2 = 1'b1; addr2 = a;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        req2  = (mode == 1);
        addr2 = (mode == 1) ? 32'd8 : a;
      end
      if (k == 2) req2 = 1'b0;
      if (mode == 2) begin
        we2 = (k == 2); waddr2 = 10'd5; wdata2 = 32'h5555_5555;
      end
      @(negedge clk);
      if (k == 1) busy_k1 = busy2;
      if (ack2) begin
        r.inst = inst2; r.err = err2; r.k = k;
        obs_q.push_back(r);
      end
    end
    end_busy = busy2;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    @(negedge clk);
    checks += 8;
    if (ack2 !== 1'b0)   begin errors++; $display("FAIL reset_ack2 got %b expected 0", ack2); end
    if (inst2 !== 32'h0) begin errors++; $display("FAIL reset_inst2 got %h expected 0", inst2); end
    if (err2 !== 1'b0)   begin errors++; $display("FAIL reset_err2 got %b expected 0", err2); end
    if (busy2 !== 1'b0)  begin errors++; $display("FAIL reset_busy2 got %b expected 0", busy2); end
    if (ack0 !== 1'b0)   begin errors++; $display("FAIL reset_ack0 got %b expected 0", ack0); end
    if (inst0 !== 32'h0) begin errors++; $display("FAIL reset_inst0 got %h expected 0", inst0); end
    if (err0 !== 1'b0)   begin errors++; $display("FAIL reset_err0 got %b expected 0", err0); end
    if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy0 got %b expected 0", busy0); end
  endtask

  task automatic test_load_fetch;
    resp_t e, o;
    wr2(10'd0, 32'h3C01_0020);
    e.inst = 32'h3C01_0020; e.err = 1'b0; e.k = 3;
    exp_q.push_back(e);
    run_fetch2(32'h0, 0);
    checks += 3;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL load_fetch_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    if (busy_k1 !== 1'b1)  begin errors++; $display("FAIL load_fetch_busy_wait got %b expected 1", busy_k1); end
    if (end_busy !== 1'b0) begin errors++; $display("FAIL load_fetch_busy_idle got %b expected 0", end_busy); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks += 3;
      if (o.inst !== e.inst) begin errors++; $display("FAIL load_fetch_inst got %h expected %h", o.inst, e.inst); end
      if (o.err !== e.err)   begin errors++; $display("FAIL load_fetch_err got %b expected %b", o.err, e.err); end
      if (o.k != e.k)        begin errors++; $display("FAIL load_fetch_latency got %0d expected %0d", o.k, e.k); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_faults;
    resp_t e, o;
`ifdef INST_MEM_ERR_EN
    e.inst = 32'h0; e.err = 1'b1; e.k = 3;
`else
    e.inst = 32'h3C01_0020; e.err = 1'b0; e.k = 3;
`endif
    exp_q.push_back(e);
    exp_q.push_back(e);
    run_fetch2(32'h0000_0002, 0);
    run_fetch2(32'h0000_1000, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL faults_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks += 3;
      if (o.inst !== e.inst) begin errors++; $display("FAIL faults_inst got %h expected %h", o.inst, e.inst); end
      if (o.err !== e.err)   begin errors++; $display("FAIL faults_err got %b expected %b", o.err, e.err); end
      if (o.k != e.k)        begin errors++; $display("FAIL faults_latency got %0d expected %0d", o.k, e.k); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_collision;
    resp_t e, o;
    wr2(10'd5, 32'hAAAA_AAAA);
    e.inst = 32'hAAAA_AAAA; e.err = 1'b0; e.k = 3; exp_q.push_back(e);
    e.inst = 32'h5555_5555; exp_q.push_back(e);
    run_fetch2(32'd20, 2);
    run_fetch2(32'd20, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL collision_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks += 2;
      if (o.inst !== e.inst) begin errors++; $display("FAIL collision_inst got %h expected %h", o.inst, e.inst); end
      if (o.err !== e.err)   begin errors++; $display("FAIL collision_err got %b expected %b", o.err, e.err); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wait_ignore;
    resp_t e, o;
    wr2(10'd2, 32'hBEEF_0002);
    e.inst = 32'h3C01_0020; e.err = 1'b0; e.k = 3; exp_q.push_back(e);
    run_fetch2(32'h0, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wait_ignore_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks += 2;
      if (o.inst !== e.inst) begin errors++; $display("FAIL wait_ignore_inst got %h expected %h", o.inst, e.inst); end
      if (o.k != e.k)        begin errors++; $display("FAIL wait_ignore_latency got %0d expected %0d", o.k, e.k); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid;
    resp_t e, o;
    int acks;
    wr2(10'd6, 32'h1111_1111);
    @(posedge clk); #1;
    req2 = 1'b1; addr2 = 32'd24;
    @(posedge clk); #1;
    req2 = 1'b0;
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL reset_mid_busy_before got %b expected 1", busy2); end
    #1 rst = 1'b0;
    #1;
    checks += 4;
    if (ack2 !== 1'b0)   begin errors++; $display("FAIL reset_mid_ack got %b expected 0", ack2); end
    if (busy2 !== 1'b0)  begin errors++; $display("FAIL reset_mid_busy got %b expected 0", busy2); end
    if (inst2 !== 32'h0) begin errors++; $display("FAIL reset_mid_inst got %h expected 0", inst2); end
    if (err2 !== 1'b0)   begin errors++; $display("FAIL reset_mid_err got %b expected 0", err2); end
    we2 = 1'b1; waddr2 = 10'd6; wdata2 = 32'hDEAD_DEAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    we2 = 1'b0;
    rst = 1'b1;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack2) acks++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL reset_mid_stray_ack got %0d expected 0", acks); end
    e.inst = 32'h1111_1111; e.err = 1'b0; e.k = 3; exp_q.push_back(e);
    run_fetch2(32'd24, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL reset_mid_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.inst !== e.inst) begin errors++; $display("FAIL reset_mid_write_blocked got %h expected %h", o.inst, e.inst); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    resp_t e, o, r;
    for (int i = 0; i < 4; i++) wr0(ADDR_W'(i), 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      e.inst = 32'(i + 1); e.err = 1'b0; e.k = i + 1; exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k < 4) addr0 = 32'(4 * k);
      if (k == 4) req0 = 1'b0;
      @(negedge clk);
      if (ack0) begin
        r.inst = inst0; r.err = err0; r.k = k;
        obs_q.push_back(r);
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks += 3;
      if (o.inst !== e.inst) begin errors++; $display("FAIL b2b_inst got %h expected %h", o.inst, e.inst); end
      if (o.err !== e.err)   begin errors++; $display("FAIL b2b_err got %b expected %b", o.err, e.err); end
      if (o.k != e.k)        begin errors++; $display("FAIL b2b_cycle got %0d expected %0d", o.k, e.k); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    rst = 1'b0;
    req2 = 1'b0; addr2 = '0; we2 = 1'b0; waddr2 = '0; wdata2 = '0;
    req0 = 1'b0; addr0 = '0; we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    busy_k1 = 1'b0; end_busy = 1'b0;
    test_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    test_load_fetch;
    test_faults;
    test_collision;
    test_wait_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
